// File: rtl/memory_access_if.sv
// Execute-to-memory handshake, data-memory port and writeback bundle for memory_access.
interface memory_access_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  logic            ex_valid;
  logic            ex_ready;
  logic            ex_memread;
  logic            ex_memwrite;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_addr;
  logic [XLEN-1:0] ex_wdata;
  logic [XLEN-1:0] ex_result;
  logic [RW-1:0]   ex_rd_s;
  logic            ex_regf_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_rmask;
  logic [3:0]      dmem_wmask;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_resp;
  logic            wb_valid;
  logic [RW-1:0]   wb_rd_s;
  logic            wb_regf_we;
  logic [XLEN-1:0] wb_rd_v;
  logic            misalign;

  modport slave (
    input  ex_valid, ex_memread, ex_memwrite, ex_funct3, ex_addr, ex_wdata,
           ex_result, ex_rd_s, ex_regf_we, dmem_rdata, dmem_resp,
    output ex_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
           wb_valid, wb_rd_s, wb_regf_we, wb_rd_v, misalign
  );

  modport master (
    output ex_valid, ex_memread, ex_memwrite, ex_funct3, ex_addr, ex_wdata,
           ex_result, ex_rd_s, ex_regf_we, dmem_rdata, dmem_resp,
    input  ex_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
           wb_valid, wb_rd_s, wb_regf_we, wb_rd_v, misalign
  );
endinterface

// File: rtl/memory_access.sv
// Memory stage: issues one aligned data-memory access at a time, realigns load data
// and retires every accepted instruction to writeback as a single-cycle pulse.
module memory_access (
  input  logic            clk,
  input  logic            rst,
  memory_access_if.slave  bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      rmask_q, rmask_d;
  logic [3:0]      wmask_q, wmask_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      off_q, off_d;
  logic            load_q, load_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic            we_q, we_d;
  logic            wb_valid_q, wb_valid_d;
  logic [RW-1:0]   wb_rd_s_q, wb_rd_s_d;
  logic            wb_we_q, wb_we_d;
  logic [XLEN-1:0] wb_rd_v_q, wb_rd_v_d;
  logic            misalign_q, misalign_d;

  logic            is_mem;
  logic            misal;
  logic            illegal;
  logic [3:0]      mask_base;
  logic [3:0]      mask;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_val;

  // Decode of the incoming access and realignment of the returning load data.
  always_comb begin
    is_mem = bus.ex_memread | bus.ex_memwrite;
    case (bus.ex_funct3[1:0])
      2'b00:   begin mask_base = 4'b0001; misal = 1'b0;            end
      2'b01:   begin mask_base = 4'b0011; misal = bus.ex_addr[0];  end
      default: begin mask_base = 4'b1111; misal = |bus.ex_addr[1:0]; end
    endcase
    illegal = misal || (bus.ex_funct3 == 3'b011) || (bus.ex_funct3[2:1] == 2'b11);
    mask    = 4'(mask_base << bus.ex_addr[1:0]);
    shifted = bus.dmem_rdata >> {off_q, 3'b000};
    case (funct3_q[1:0])
      2'b00:   load_val = {{24{~funct3_q[2] & shifted[7]}},  shifted[7:0]};
      2'b01:   load_val = {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rmask_d    = rmask_q;
    wmask_d    = wmask_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    load_d     = load_q;
    rd_d       = rd_q;
    we_d       = we_q;
    wb_valid_d = 1'b0;
    wb_rd_s_d  = '0;
    wb_we_d    = 1'b0;
    wb_rd_v_d  = '0;
    misalign_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ex_valid) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_rd_s_d  = bus.ex_rd_s;
            wb_we_d    = bus.ex_regf_we && (bus.ex_rd_s != '0);
            wb_rd_v_d  = bus.ex_result;
          end else if (illegal) begin
            wb_valid_d = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d  = S_WAIT;
            addr_d   = {bus.ex_addr[XLEN-1:2], 2'b00};
            off_d    = bus.ex_addr[1:0];
            funct3_d = bus.ex_funct3;
            load_d   = ~bus.ex_memwrite;
            rd_d     = bus.ex_rd_s;
            we_d     = bus.ex_regf_we;
            wdata_d  = bus.ex_wdata << {bus.ex_addr[1:0], 3'b000};
            rmask_d  = bus.ex_memwrite ? 4'b0000 : mask;
            wmask_d  = bus.ex_memwrite ? mask : 4'b0000;
          end
        end
      end
      S_WAIT: begin
        if (bus.dmem_resp) begin
          state_d    = S_IDLE;
          addr_d     = '0;
          wdata_d    = '0;
          rmask_d    = '0;
          wmask_d    = '0;
          wb_valid_d = 1'b1;
          if (load_q) begin
            wb_rd_s_d = rd_q;
            wb_we_d   = we_q && (rd_q != '0);
            wb_rd_v_d = load_val;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      rmask_q    <= '0;
      wmask_q    <= '0;
      funct3_q   <= '0;
      off_q      <= '0;
      load_q     <= 1'b0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_s_q  <= '0;
      wb_we_q    <= 1'b0;
      wb_rd_v_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rmask_q    <= rmask_d;
      wmask_q    <= wmask_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      load_q     <= load_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_s_q  <= wb_rd_s_d;
      wb_we_q    <= wb_we_d;
      wb_rd_v_q  <= wb_rd_v_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.ex_ready   = ready_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_rmask = rmask_q;
  assign bus.dmem_wmask = wmask_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_rd_s    = wb_rd_s_q;
  assign bus.wb_regf_we = wb_we_q;
  assign bus.wb_rd_v    = wb_rd_v_q;
  assign bus.misalign   = misalign_q;
endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: transaction-level reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_memory_access;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  memory_access_if bus ();

  memory_access dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding access, outputs derived by arithmetic on bytes.
  bit          m_ok = 1'b0;
  bit          m_busy;
  bit          p_load;
  int          p_f3, p_off, p_rd;
  bit          p_we;
  logic        e_ready, e_wbv, e_we, e_mis;
  logic [3:0]  e_rmask, e_wmask;
  logic [4:0]  e_rd;
  logic [31:0] e_addr, e_wdata, e_rdv;

  function automatic int nbytes(input int f3);
    if (f3 % 4 == 0) return 1;
    if (f3 % 4 == 1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] rdata, input int f3, input int off);
    logic [63:0] v;
    int n;
    n = nbytes(f3);
    v = 64'(rdata) / (64'd1 << (8 * off));
    v = v % (64'd1 << (8 * n));
    if (f3 < 4 && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return 32'(v);
  endfunction

  always @(posedge clk) begin
    int f3, off, n;
    if (!rst) begin
      m_ok = 1'b1; m_busy = 1'b0;
      e_ready = 1'b1; e_wbv = 1'b0; e_we = 1'b0; e_mis = 1'b0;
      e_rmask = '0; e_wmask = '0; e_rd = '0; e_addr = '0; e_wdata = '0; e_rdv = '0;
    end else begin
      e_wbv = 1'b0; e_mis = 1'b0; e_rd = '0; e_we = 1'b0; e_rdv = '0;
      if (m_busy) begin
        if (bus.dmem_resp) begin
          m_busy = 1'b0; e_wbv = 1'b1; e_rmask = '0; e_wmask = '0;
          if (p_load) begin
            e_rd  = 5'(p_rd);
            e_we  = p_we && (p_rd != 0);
            e_rdv = load_ext(bus.dmem_rdata, p_f3, p_off);
          end
        end
      end else if (bus.ex_valid) begin
        f3  = int'(bus.ex_funct3);
        off = int'(bus.ex_addr[1:0]);
        n   = nbytes(f3);
        if (!(bus.ex_memread || bus.ex_memwrite)) begin
          e_wbv = 1'b1; e_rd = bus.ex_rd_s; e_rdv = bus.ex_result;
          e_we  = bus.ex_regf_we && (bus.ex_rd_s != 5'd0);
        end else if (f3 == 3 || f3 == 6 || f3 == 7 || (off % n) != 0) begin
          e_wbv = 1'b1; e_mis = 1'b1;
        end else begin
          m_busy = 1'b1;
          p_load = !bus.ex_memwrite; p_f3 = f3; p_off = off;
          p_rd = int'(bus.ex_rd_s); p_we = bus.ex_regf_we;
          e_addr  = bus.ex_addr - 32'(off);
          e_wdata = 32'(64'(bus.ex_wdata) * (64'd1 << (8 * off)));
          e_rmask = p_load ? 4'(((1 << n) - 1) << off) : 4'd0;
          e_wmask = p_load ? 4'd0 : 4'(((1 << n) - 1) << off);
        end
      end
      e_ready = !m_busy;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("ex_ready", 32'(bus.ex_ready), 32'(e_ready));
      chk("dmem_rmask", 32'(bus.dmem_rmask), 32'(e_rmask));
      chk("dmem_wmask", 32'(bus.dmem_wmask), 32'(e_wmask));
      chk("wb_valid", 32'(bus.wb_valid), 32'(e_wbv));
      chk("misalign", 32'(bus.misalign), 32'(e_mis));
      if (m_busy) begin
        chk("dmem_addr", bus.dmem_addr, e_addr);
        chk("dmem_wdata", bus.dmem_wdata, e_wdata);
      end
      if (e_wbv) begin
        chk("wb_rd_s", 32'(bus.wb_rd_s), 32'(e_rd));
        chk("wb_regf_we", 32'(bus.wb_regf_we), 32'(e_we));
        chk("wb_rd_v", bus.wb_rd_v, e_rdv);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one memory op; lat = cycles in WAIT including the response cycle, 0 for illegal.
  task automatic mem_op(input logic rd_i, input logic wr_i, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [4:0] rd, input logic we,
                        input int lat, output logic [3:0] rm, output logic [3:0] wm,
                        output logic [31:0] wd);
    bus.ex_valid = 1'b1; bus.ex_memread = rd_i; bus.ex_memwrite = wr_i;
    bus.ex_funct3 = f3; bus.ex_addr = addr; bus.ex_wdata = wdata;
    bus.ex_rd_s = rd; bus.ex_regf_we = we; bus.ex_result = 32'h5555_AAAA;
    bus.dmem_rdata = rdata;
    tick();
    bus.ex_valid = 1'b0; bus.ex_memread = 1'b0; bus.ex_memwrite = 1'b0;
    rm = bus.dmem_rmask; wm = bus.dmem_wmask; wd = bus.dmem_wdata;
    if (lat > 0) begin
      for (int i = 1; i < lat; i++) begin
        // A non-memory instruction offered mid-access must not be accepted.
        bus.ex_valid = (i == 1);
        bus.ex_result = 32'hDEAD_0000; bus.ex_rd_s = 5'd3; bus.ex_regf_we = 1'b1;
        tick();
        bus.ex_valid = 1'b0;
      end
      bus.dmem_resp = 1'b1;
      tick();
      bus.dmem_resp = 1'b0;
    end
  endtask

  typedef struct {
    logic rd_i, wr_i; logic [2:0] f3; logic [31:0] addr, wdata, rdata;
    logic [4:0] rd; logic we; int lat;
  } vec_t;

  vec_t vt [15];

  initial begin
    logic [3:0]  rm, wm;
    logic [31:0] wd;
    bus.ex_valid = 1'b0; bus.ex_memread = 1'b0; bus.ex_memwrite = 1'b0;
    bus.ex_funct3 = '0; bus.ex_addr = '0; bus.ex_wdata = '0; bus.ex_result = '0;
    bus.ex_rd_s = '0; bus.ex_regf_we = 1'b0; bus.dmem_rdata = '0; bus.dmem_resp = 1'b0;
    rst = 1'b0;
    tick(); tick();
    chk("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
    chk("rst_dmem_addr", bus.dmem_addr, 32'd0);
    chk("rst_rmask", 32'(bus.dmem_rmask), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    rst = 1'b1;

    bus.ex_valid = 1'b1; bus.ex_result = 32'h1234; bus.ex_rd_s = 5'd5; bus.ex_regf_we = 1'b1;
    tick();
    bus.ex_valid = 1'b0;
    chk("alu_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("alu_wb_rd_v", bus.wb_rd_v, 32'h1234);
    chk("alu_wb_regf_we", 32'(bus.wb_regf_we), 32'd1);
    chk("alu_ex_ready", 32'(bus.ex_ready), 32'd1);
    tick();
    chk("alu_wb_pulse", 32'(bus.wb_valid), 32'd0);

    mem_op(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF_FF00, 5'd7, 1'b1, 3, rm, wm, wd);
    chk("lb_rmask", 32'(rm), 32'h8);
    chk("lb_wb_rd_v", bus.wb_rd_v, 32'hFFFF_FF80);
    chk("lb_ex_ready", 32'(bus.ex_ready), 32'd1);
    mem_op(1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FF_FF00, 5'd7, 1'b1, 3, rm, wm, wd);
    chk("lbu_wb_rd_v", bus.wb_rd_v, 32'h0000_0080);

    mem_op(1'b0, 1'b1, 3'b001, 32'h2002, 32'hABCD, 32'h0, 5'd9, 1'b1, 1, rm, wm, wd);
    chk("sh_wmask", 32'(wm), 32'hC);
    chk("sh_wdata", wd, 32'hABCD_0000);
    chk("sh_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("sh_wb_regf_we", 32'(bus.wb_regf_we), 32'd0);

    mem_op(1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 32'h0, 5'd4, 1'b1, 0, rm, wm, wd);
    chk("lw_mis_rmask", 32'(rm), 32'd0);
    chk("lw_mis_misalign", 32'(bus.misalign), 32'd1);
    chk("lw_mis_wb_regf_we", 32'(bus.wb_regf_we), 32'd0);
    chk("lw_mis_ex_ready", 32'(bus.ex_ready), 32'd1);
    tick();
    chk("lw_mis_pulse", 32'(bus.misalign), 32'd0);

    bus.ex_valid = 1'b1; bus.ex_memread = 1'b1; bus.ex_funct3 = 3'b010; bus.ex_addr = 32'h4000;
    tick();
    bus.ex_valid = 1'b0; bus.ex_memread = 1'b0;
    chk("rstw_rmask_before", 32'(bus.dmem_rmask), 32'hF);
    rst = 1'b0;
    tick();
    rst = 1'b1; bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    chk("rstw_rmask", 32'(bus.dmem_rmask), 32'd0);
    chk("rstw_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rstw_ex_ready", 32'(bus.ex_ready), 32'd1);

    vt[0]  = '{1'b1, 1'b0, 3'b001, 32'h5002, 32'h0, 32'h8001_1234, 5'd10, 1'b1, 2};
    vt[1]  = '{1'b1, 1'b0, 3'b101, 32'h5002, 32'h0, 32'h8001_1234, 5'd10, 1'b1, 2};
    vt[2]  = '{1'b1, 1'b0, 3'b001, 32'h5000, 32'h0, 32'h0000_7FFF, 5'd11, 1'b1, 1};
    vt[3]  = '{1'b0, 1'b1, 3'b000, 32'h6001, 32'h5A, 32'h0, 5'd12, 1'b1, 2};
    vt[4]  = '{1'b0, 1'b1, 3'b010, 32'h7000, 32'hDEAD_BEEF, 32'h0, 5'd13, 1'b1, 4};
    vt[5]  = '{1'b1, 1'b1, 3'b010, 32'h7004, 32'h1357_9BDF, 32'hFFFF_FFFF, 5'd14, 1'b1, 1};
    vt[6]  = '{1'b1, 1'b0, 3'b010, 32'h8000, 32'h0, 32'h1122_3344, 5'd0, 1'b1, 1};
    vt[7]  = '{1'b1, 1'b0, 3'b010, 32'h8008, 32'h0, 32'hCAFE_F00D, 5'd31, 1'b1, 1};
    vt[8]  = '{1'b1, 1'b0, 3'b000, 32'h9001, 32'h0, 32'h0000_7F00, 5'd15, 1'b0, 2};
    vt[9]  = '{1'b1, 1'b0, 3'b011, 32'hA000, 32'h0, 32'h0, 5'd16, 1'b1, 0};
    vt[10] = '{1'b0, 1'b1, 3'b110, 32'hA000, 32'h0, 32'h0, 5'd17, 1'b1, 0};
    vt[11] = '{1'b0, 1'b1, 3'b001, 32'hA001, 32'h0, 32'h0, 5'd18, 1'b1, 0};
    vt[12] = '{1'b1, 1'b0, 3'b001, 32'hA003, 32'h0, 32'h0, 5'd19, 1'b1, 0};
    vt[13] = '{1'b1, 1'b0, 3'b111, 32'hA000, 32'h0, 32'h0, 5'd20, 1'b1, 0};
    vt[14] = '{1'b1, 1'b0, 3'b101, 32'hB002, 32'h0, 32'hFFFF_0000, 5'd21, 1'b1, 3};
    for (int i = 0; i < 15; i++) begin
      mem_op(vt[i].rd_i, vt[i].wr_i, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].rdata,
             vt[i].rd, vt[i].we, vt[i].lat, rm, wm, wd);
      if (i == 0) chk("lh_wb_rd_v", bus.wb_rd_v, 32'hFFFF_8001);
      if (i == 1) chk("lhu_wb_rd_v", bus.wb_rd_v, 32'h0000_8001);
      if (i == 3) chk("sb_wdata", wd, 32'h0000_5A00);
      if (i == 5) chk("ldst_wmask", 32'(wm), 32'hF);
      if (i == 6) chk("lw_x0_wb_regf_we", 32'(bus.wb_regf_we), 32'd0);
      if (i == 14) chk("lhu_hi_wb_rd_v", bus.wb_rd_v, 32'h0000_FFFF);
      if (i % 3 == 0) tick();
    end

    bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    chk("idle_resp_wb_valid", 32'(bus.wb_valid), 32'd0);
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
